// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide: one result bit per clock, then a sign-fix cycle.
// Latency WIDTH+1 cycles start->done; start and MTHI/MTLO are ignored while busy (no queueing).
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opr;
    logic               is_div, sign_a, sign_b, b_zero;

    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

    assign neg_a = ~op[0] & a[WIDTH-1];
    assign neg_b = ~op[0] & b[WIDTH-1];
    assign abs_a = neg_a ? -a : a;
    assign abs_b = neg_b ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opr : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opr};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // With a zero divisor the remainder ends up as |a|, so the sign fix recovers raw a in HI
    assign quo      = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];
    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    assign quo_fix  = b_zero ? {WIDTH{1'b1}} : ((sign_a ^ sign_b) ? -quo : quo);
    assign rem_fix  = sign_a ? -rem : rem;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (nrst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt         <= '0;
            acc         <= '0;
            opr         <= '0;
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            b_zero      <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) && is_div && b_zero;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div <= op[1];
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        b_zero <= op[1] && (b == '0);
                        cnt    <= '0;
                        if (op[1]) begin
                            acc <= {{WIDTH{1'b0}}, abs_a};
                            opr <= abs_b;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, abs_b};
                            opr <= abs_a;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv (WIDTH = 32) with hand-computed HI/LO results.
module tb_mips_muldiv;
    logic        clk = 1'b0;
    logic        nrst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;
    int lat, dcount;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .nrst(nrst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op, check busy rises and that done arrives WIDTH+1 edges after the start edge
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] aa,
                         input logic [31:0] bb);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd33);
    endtask

    initial begin
        nrst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz",  64'(div_by_zero), 64'd0);
        chk("rst_hi",   64'(hi), 64'd0);
        chk("rst_lo",   64'(lo), 64'd0);
        @(negedge clk);
        nrst = 1'b0;

        do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
        chk("multu_max_lo", 64'(lo), 64'h00000001);
        chk("multu_max_dbz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #1;
        chk("done_pulse_width", 64'(done), 64'd0);

        do_op("mult_neg", 2'b00, 32'hFFFFFFF9, 32'd3);
        chk("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

        // Issued in the done cycle of the previous op: back-to-back acceptance
        do_op("mult_min", 2'b00, 32'h80000000, 32'h80000000);
        chk("mult_min_hi", 64'(hi), 64'h40000000);
        chk("mult_min_lo", 64'(lo), 64'h00000000);

        do_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2);
        chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

        do_op("divu", 2'b11, 32'd7, 32'd2);
        chk("divu_lo", 64'(lo), 64'd3);
        chk("divu_hi", 64'(hi), 64'd1);

        do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo",  64'(lo), 64'h80000000);
        chk("div_ovf_hi",  64'(hi), 64'd0);
        chk("div_ovf_dbz", 64'(div_by_zero), 64'd0);

        do_op("divu_zero", 2'b11, 32'd5, 32'd0);
        chk("divu_zero_lo",  64'(lo), 64'hFFFFFFFF);
        chk("divu_zero_hi",  64'(hi), 64'd5);
        chk("divu_zero_dbz", 64'(div_by_zero), 64'd1);

        do_op("div_zero_neg", 2'b10, 32'hFFFFFFF9, 32'd0);
        chk("div_zero_neg_lo",  64'(lo), 64'hFFFFFFFF);
        chk("div_zero_neg_hi",  64'(hi), 64'hFFFFFFF9);
        chk("div_zero_neg_dbz", 64'(div_by_zero), 64'd1);

        // start held high with op/a toggling, and MTHI attempted mid-run
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'h12345678; b = 32'h00000010;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
            if (i == 33) begin
                chk("hold_hi", 64'(hi), 64'h00000001);
                chk("hold_lo", 64'(lo), 64'h23456780);
            end
            if (i == 32) start = 1'b0;
            op    = 2'(i);
            a     = a + 32'd1;
            hi_we = (i >= 9 && i <= 12);
            wdata = 32'hDEAD0000;
        end
        chk("hold_done_count", 64'(dcount), 64'd1);
        chk("hold_hi_after",   64'(hi), 64'h00000001);

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h00001234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h00001234);
        chk("mthi_lo_kept", 64'(lo), 64'h23456780);

        // Reset asserted so that it lands on the 10th RUN edge
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi",   64'(hi), 64'd0);
        chk("abort_lo",   64'(lo), 64'd0);
        nrst = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);

        do_op("divu_after", 2'b11, 32'd100, 32'd7);
        chk("divu_after_lo", 64'(lo), 64'd14);
        chk("divu_after_hi", 64'(hi), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers, added beside the ALU so the single-cycle MIPS core can gain MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. The core launches an operation with a one-cycle `start` and stalls on `busy` only when it needs HI/LO. The unit produces one result bit per clock using radix-2 shift-add for multiply and restoring division for divide. It then applies a sign-fix cycle and pulses `done`.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  reset; synchronous, active-high (1 = reset).
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend (rs); captured with `start`.
- b  in  WIDTH  multiplier / divisor (rt); captured with `start`.
- hi_we  in  1  MTHI: write `wdata` into HI.
- lo_we  in  1  MTLO: write `wdata` into LO.
- wdata  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in progress (RUN or FIX).
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  pulses together with `done` for DIV/DIVU with b == 0.
- hi  out  WIDTH  HI register (MFHI source).
- lo  out  WIDTH  LO register (MFLO source).

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → FIX after WIDTH iterations.
  - FIX → IDLE.
- On acceptance, capture `op`, the sign flags `a[WIDTH-1]`/`b[WIDTH-1]` (signed ops only), and the magnitudes |a|, |b|. Unsigned ops use the raw values.
- MULT/MULTU: 2·WIDTH-bit accumulator; each RUN cycle conditionally adds the multiplicand, then shifts right one bit. In FIX, negate the 2·WIDTH product if sign_a ^ sign_b. Then HI = upper WIDTH bits and LO = lower WIDTH bits.
- DIV/DIVU: restoring division, one quotient bit per RUN cycle. In FIX:
  - negate the quotient if sign_a ^ sign_b;
  - negate the remainder if sign_a (truncating semantics).
  - LO = quotient, HI = remainder.
- Divide by zero (b == 0, either divide op): runs full latency. Result is LO = all ones and HI = a as captured (raw, unsigned view). `div_by_zero` = 1 with `done`.
- Signed overflow (DIV of 0x80…0 by −1): LO = 0x80…0, HI = 0. This is natural wrap with no flag.
- MTHI/MTLO: accepted only when `busy` = 0; HI/LO update at the same edge.
  - `start` in the same cycle is also accepted, and its result later overwrites HI/LO.
  - `hi_we`/`lo_we` while busy are ignored.
- `start` while busy is ignored, with no queueing. `a`, `b` and `op` may change freely after acceptance.
- HI/LO change only on MTHI/MTLO, on the FIX→IDLE edge, or on reset.

## Timing
- Reset values: busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0; state = IDLE; internal counter cleared.
- `start` sampled high at edge k (IDLE):
  - busy = 1 from after edge k until edge k+WIDTH+1.
  - RUN iterations occur at edges k+1 … k+WIDTH.
  - FIX is the cycle after edge k+WIDTH; at edge k+WIDTH+1 HI/LO are written, busy falls, and `done` rises for exactly one cycle.
- Latency is WIDTH+1 cycles from acceptance to a valid HI/LO (33 for WIDTH = 32).
- Back-to-back: a new `start` may be sampled in the cycle `done` is high (IDLE), giving a throughput of one op per WIDTH+2 cycles.
- Reset mid-operation aborts at the next edge: outputs return to reset values, no `done` pulse, and HI/LO are cleared.
- Everything is synchronous; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then MULTU with a = 0xFFFFFFFF, b = 0xFFFFFFFF (WIDTH = 32) → done exactly 33 cycles after the start edge; hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT with a = −7, b = 3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. MULT with a = 0x80000000, b = 0x80000000 → hi = 0x40000000, lo = 0.
- DIV with a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU with a = 7, b = 2 → lo = 3, hi = 1.
- DIV with a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_by_zero = 0. DIVU with a = 5, b = 0 → lo = 0xFFFFFFFF, hi = 5, and div_by_zero pulses with done.
- Hold `start` high and toggle `op` throughout a MULTU, with hi_we = 1 mid-run → only one done, result of the first op, HI unaffected by the write. Then idle hi_we with wdata = 0x1234 → hi = 0x1234 one edge later.
- Assert nrst during the 10th RUN cycle → busy = 0, hi = lo = 0 next cycle, no done pulse. A fresh DIVU 100/7 then gives lo = 14, hi = 2.
